// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
//
// Monitors a multiplexed 7-segment display bus. Each cycle it samples the
// tuple {enable, digit_sel, seg}. A tuple must stay identical for
// STABLE_CYCLES samples before it is committed. A committed tuple is decoded
// back to its hex nibble, and the nibble is written into a per-digit
// value/valid register file.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   seg_in       segment lines {g,f,e,d,c,b,a}, active-high
//   digit_sel    one-hot digit select, active-high
//   enable       display enable; 0 blanks the display (seg treated as 0)
//   value_out    decoded nibbles; digit i occupies bits [4i+3:4i]
//   digit_valid  1 = nibble i holds a legally decoded value
//   update       one-cycle pulse; a nibble was written this cycle
//   update_idx   index of the written digit (meaningful while update=1)
//   code_err     one-cycle pulse; illegal pattern or non-one-hot select
// ---------------------------------------------------------------------------
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    input  logic                    enable,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    code_err
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Returns {legal, nibble}. legal=0 marks a pattern that is not in the table.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            7'b0111111: res = 5'b1_0000;
            7'b0000110: res = 5'b1_0001;
            7'b1011011: res = 5'b1_0010;
            7'b1001111: res = 5'b1_0011;
            7'b1100110: res = 5'b1_0100;
            7'b1101101: res = 5'b1_0101;
            7'b1111101: res = 5'b1_0110;
            7'b0000111: res = 5'b1_0111;
            7'b1111111: res = 5'b1_1000;
            7'b1100111: res = 5'b1_1001;
            7'b1110111: res = 5'b1_1010;
            7'b1111100: res = 5'b1_1011;
            7'b0111001: res = 5'b1_1100;
            7'b1011110: res = 5'b1_1101;
            7'b1111001: res = 5'b1_1110;
            7'b1110001: res = 5'b1_1111;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // ---------------- sample / stability stage ----------------
    logic                  en_q,     en_d;
    logic [NUM_DIGITS-1:0] sel_q,    sel_d;
    logic [6:0]            seg_q,    seg_d;
    logic                  no_prev_q, no_prev_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  pend_q,   pend_d;
    logic                  changed;

    always_comb begin
        en_d      = enable;
        sel_d     = digit_sel;
        seg_d     = enable ? seg_in : 7'b000_0000;
        no_prev_d = 1'b0;
        changed   = no_prev_q || (en_d != en_q) || (sel_d != sel_q) || (seg_d != seg_q);
        if (changed) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        // Commit only on the cycle the count arrives at the threshold. When
        // STABLE_CYCLES=1 a change alone lands there, even if the count was
        // already saturated for the previous tuple.
        pend_d = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            sel_q     <= '0;
            seg_q     <= 7'b000_0000;
            no_prev_q <= 1'b1;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            no_prev_q <= no_prev_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
        end
    end

    // ---------------- commit stage ----------------
    // pend_q says that the tuple now held in sel_q/seg_q has just become stable.
    logic [4*NUM_DIGITS-1:0] value_q,  value_d;
    logic [NUM_DIGITS-1:0]   valid_q,  valid_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q,    idx_d;
    logic                    err_q,    err_d;
    logic                    sel_one_hot;
    logic                    seg_blank;
    logic [4:0]              dec;
    logic [2:0]              sel_idx;

    always_comb begin
        value_d  = value_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        idx_d    = idx_q;
        err_d    = 1'b0;

        sel_one_hot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
        seg_blank   = (seg_q == 7'b000_0000);
        dec         = decode_seg(seg_q);

        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                sel_idx = 3'(i);
            end
        end

        if (pend_q && (sel_q != '0)) begin
            if (!sel_one_hot) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        if (seg_blank) begin
                            valid_d[i] = 1'b0;
                        end else if (dec[4]) begin
                            value_d[4*i +: 4] = dec[3:0];
                            valid_d[i]        = 1'b1;
                        end else begin
                            valid_d[i] = 1'b0;
                        end
                    end
                end
                if (!seg_blank) begin
                    if (dec[4]) begin
                        update_d = 1'b1;
                        idx_d    = sel_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q  <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            idx_q    <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign value_out   = value_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign update_idx  = idx_q;
    assign code_err    = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel;
    logic        enable;
    logic [15:0] value_out;
    logic [3:0]  digit_valid;
    logic        update;
    logic [2:0]  update_idx;
    logic        code_err;

    int errors = 0;
    int checks = 0;

    seg7_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit_sel   (digit_sel),
        .enable      (enable),
        .value_out   (value_out),
        .digit_valid (digit_valid),
        .update      (update),
        .update_idx  (update_idx),
        .code_err    (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic        en;
        int          hold;
        logic [15:0] exp_val;
        logic [3:0]  exp_valid;
        int          exp_ups;
        int          exp_errs;
        logic [2:0]  exp_idx;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ups;
        int errs;

        //        sel      seg         en  hold val       valid    ups errs idx
        vecs[0]  = '{4'b0001, 7'b1011011, 1'b1, 5, 16'h0002, 4'b0001, 1, 0, 3'd0};
        vecs[1]  = '{4'b0010, 7'b1001111, 1'b1, 5, 16'h0032, 4'b0011, 1, 0, 3'd1};
        vecs[2]  = '{4'b0100, 7'b1100110, 1'b1, 5, 16'h0432, 4'b0111, 1, 0, 3'd2};
        vecs[3]  = '{4'b1000, 7'b1101101, 1'b1, 5, 16'h5432, 4'b1111, 1, 0, 3'd3};
        vecs[4]  = '{4'b0001, 7'b1011011, 1'b1, 5, 16'h5432, 4'b1111, 1, 0, 3'd0};
        vecs[5]  = '{4'b0010, 7'b1001111, 1'b1, 5, 16'h5432, 4'b1111, 1, 0, 3'd1};
        vecs[6]  = '{4'b0100, 7'b1100110, 1'b1, 5, 16'h5432, 4'b1111, 1, 0, 3'd2};
        vecs[7]  = '{4'b1000, 7'b1101101, 1'b1, 5, 16'h5432, 4'b1111, 1, 0, 3'd3};
        vecs[8]  = '{4'b0010, 7'b1111111, 1'b1, 5, 16'h5482, 4'b1111, 1, 0, 3'd1};
        vecs[9]  = '{4'b0010, 7'b0000111, 1'b1, 2, 16'h5482, 4'b1111, 0, 0, 3'd1};
        vecs[10] = '{4'b0010, 7'b1111111, 1'b1, 5, 16'h5482, 4'b1111, 1, 0, 3'd1};
        vecs[11] = '{4'b0100, 7'b1010101, 1'b1, 4, 16'h5482, 4'b1011, 0, 1, 3'd2};
        vecs[12] = '{4'b0011, 7'b0000110, 1'b1, 4, 16'h5482, 4'b1011, 0, 1, 3'd0};
        vecs[13] = '{4'b0001, 7'b1111111, 1'b0, 4, 16'h5482, 4'b1010, 0, 0, 3'd0};
        vecs[14] = '{4'b0000, 7'b0000000, 1'b1, 4, 16'h5482, 4'b1010, 0, 0, 3'd0};
        vecs[15] = '{4'b0001, 7'b0111111, 1'b1, 4, 16'h5480, 4'b1011, 1, 0, 3'd0};
        vecs[16] = '{4'b0001, 7'b1110111, 1'b1, 4, 16'h548A, 4'b1011, 1, 0, 3'd0};
        vecs[17] = '{4'b0001, 7'b1111100, 1'b1, 4, 16'h548B, 4'b1011, 1, 0, 3'd0};
        vecs[18] = '{4'b0001, 7'b0111001, 1'b1, 4, 16'h548C, 4'b1011, 1, 0, 3'd0};
        vecs[19] = '{4'b0001, 7'b1011110, 1'b1, 4, 16'h548D, 4'b1011, 1, 0, 3'd0};
        vecs[20] = '{4'b0001, 7'b1111001, 1'b1, 4, 16'h548E, 4'b1011, 1, 0, 3'd0};
        vecs[21] = '{4'b0001, 7'b1111101, 1'b1, 4, 16'h5486, 4'b1011, 1, 0, 3'd0};
        vecs[22] = '{4'b0001, 7'b1100111, 1'b1, 4, 16'h5489, 4'b1011, 1, 0, 3'd0};
        vecs[23] = '{4'b0001, 7'b0000111, 1'b1, 4, 16'h5487, 4'b1011, 1, 0, 3'd0};

        rst       = 1'b1;
        seg_in    = 7'b000_0000;
        digit_sel = 4'b0000;
        enable    = 1'b0;
        repeat (3) tick();
        chk("reset_value", value_out, 16'h0000);
        chk("reset_valid", digit_valid, 4'b0000);
        chk("reset_update", update, 1'b0);
        chk("reset_err", code_err, 1'b0);
        rst = 1'b0;

        // First commit after reset lands on the 4th edge
        digit_sel = 4'b0001;
        seg_in    = 7'b0000110;
        enable    = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("lat_update", update, (e == 4) ? 1 : 0);
            chk("lat_err", code_err, 1'b0);
            if (e == 4) chk("lat_idx", update_idx, 3'd0);
        end
        chk("lat_value", value_out, 16'h0001);
        chk("lat_valid", digit_valid, 4'b0001);

        for (int r = 0; r < NV; r++) begin
            digit_sel = vecs[r].sel;
            seg_in    = vecs[r].seg;
            enable    = vecs[r].en;
            ups  = 0;
            errs = 0;
            for (int c = 0; c < vecs[r].hold; c++) begin
                tick();
                if (update) begin
                    ups++;
                    chk("vec_idx", update_idx, vecs[r].exp_idx);
                end
                if (code_err) errs++;
                chk("vec_exclusive", update & code_err, 1'b0);
            end
            chk("vec_value", value_out, vecs[r].exp_val);
            chk("vec_valid", digit_valid, vecs[r].exp_valid);
            chk("vec_updates", ups, vecs[r].exp_ups);
            chk("vec_errs", errs, vecs[r].exp_errs);
        end

        // Reset in the middle of a stability window discards the pending commit
        digit_sel = 4'b1000;
        seg_in    = 7'b1110001;
        enable    = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_value", value_out, 16'h0000);
        chk("midrst_valid", digit_valid, 4'b0000);
        chk("midrst_update", update, 1'b0);
        chk("midrst_err", code_err, 1'b0);
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("inrst_update", update, 1'b0);
            chk("inrst_value", value_out, 16'h0000);
        end
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("postrst_update", update, (e == 4) ? 1 : 0);
            chk("postrst_err", code_err, 1'b0);
            if (e == 4) chk("postrst_idx", update_idx, 3'd3);
        end
        chk("postrst_value", value_out, 16'hF000);
        chk("postrst_valid", digit_valid, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
